// File: rtl/poly_horner_eval.sv
// Polynomial evaluator using Horner's method.
// Coefficients a_DEGREE..a_0 and then x are loaded one value per go strobe.
// The evaluation then runs as INIT followed by DEGREE MUL/ADD pairs.
// All arithmetic is unsigned modulo 2^DATA_W. A sticky flag records any
// intermediate value that needed more than DATA_W bits.
module poly_horner_eval #(
  parameter int DATA_W = 8,
  parameter int DEGREE = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_result,
  output logic              done,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        load_idx
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LOAD_WAIT,
    S_INIT,
    S_MUL,
    S_ADD
  } state_e;

  // The slot index must reach DEGREE+1, which is 16 when DEGREE=15.
  // The internal counter therefore has one more bit than the load_idx port.
  localparam int                IDX_W  = 5;
  localparam logic [IDX_W-1:0]  X_SLOT = IDX_W'(DEGREE + 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [3:0]          step_q;
  logic [DATA_W-1:0]   coef_q [DEGREE+1];   // coef_q[j] holds a_j
  logic [DATA_W-1:0]   x_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;
  logic                busy_q;
  logic                ovf_q;

  logic [2*DATA_W-1:0] prod_d;
  logic [DATA_W:0]     sum_d;
  logic [DATA_W-1:0]   a_step;

  // Datapath: select coefficient a_step, form the full product and the carry-extended sum.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and infers a latch.
    a_step = '0;
    for (int j = 0; j <= DEGREE; j++) begin
      if (step_q == 4'(j)) begin
        a_step = coef_q[j];
      end
    end
    prod_d = (2*DATA_W)'(acc_q) * (2*DATA_W)'(x_q);
    sum_d  = {1'b0, acc_q} + {1'b0, a_step};
  end

  // Control FSM with slot capture, accumulator and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      step_q   <= '0;
      // NOTE: the slot array is cleared on reset on purpose. A reset or an aborted load then never exposes stale operands.
      for (int j = 0; j <= DEGREE; j++) begin
        coef_q[j] <= '0;
      end
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments only, so every right-hand side sees pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (go) begin
            // Slot k holds a_(DEGREE-k); slot DEGREE+1 holds x.
            for (int k = 0; k <= DEGREE; k++) begin
              if (idx_q == IDX_W'(k)) begin
                coef_q[DEGREE-k] <= data_in;
              end
            end
            if (idx_q == X_SLOT) begin
              x_q <= data_in;
            end
            state_q <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          // Wait for go to drop, so that a held strobe captures exactly once.
          if (!go) begin
            if (idx_q < X_SLOT) begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_LOAD;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_INIT;
            end
          end
        end
        S_INIT: begin
          acc_q   <= coef_q[DEGREE];
          step_q  <= 4'(DEGREE - 1);
          ovf_q   <= 1'b0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          acc_q <= prod_d[DATA_W-1:0];
          if (|prod_d[2*DATA_W-1:DATA_W]) begin
            ovf_q <= 1'b1;
          end
          state_q <= S_ADD;
        end
        S_ADD: begin
          acc_q <= sum_d[DATA_W-1:0];
          if (sum_d[DATA_W]) begin
            ovf_q <= 1'b1;
          end
          if (step_q != 4'd0) begin
            step_q  <= step_q - 4'd1;
            state_q <= S_MUL;
          end else begin
            result_q <= sum_d[DATA_W-1:0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            state_q  <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign data_result = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign load_idx    = idx_q[3:0];

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed testbench for poly_horner_eval.
// It drives three instances: DEGREE=2 with DATA_W=8, DEGREE=1 with DATA_W=16,
// and DEGREE=4 with DATA_W=16.
module tb_poly_horner_eval;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  go_v;
  logic [15:0] data_in;

  logic [7:0]  res0;
  logic [15:0] res1, res2;
  logic        done0, done1, done2;
  logic        busy0, busy1, busy2;
  logic        ov0, ov1, ov2;
  logic [3:0]  idx0, idx1, idx2;

  int          sel;
  logic [15:0] r_res;
  logic        r_done, r_busy, r_ov;
  logic [3:0]  r_idx;

  logic [15:0] vec [6];
  logic [15:0] last_res [3];
  logic        last_ov [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_horner_eval #(.DATA_W(8), .DEGREE(2)) dut0 (
    .clk(clk), .resetn(resetn), .go(go_v[0]), .data_in(data_in[7:0]),
    .data_result(res0), .done(done0), .busy(busy0), .overflow(ov0), .load_idx(idx0)
  );

  poly_horner_eval #(.DATA_W(16), .DEGREE(1)) dut1 (
    .clk(clk), .resetn(resetn), .go(go_v[1]), .data_in(data_in),
    .data_result(res1), .done(done1), .busy(busy1), .overflow(ov1), .load_idx(idx1)
  );

  poly_horner_eval #(.DATA_W(16), .DEGREE(4)) dut2 (
    .clk(clk), .resetn(resetn), .go(go_v[2]), .data_in(data_in),
    .data_result(res2), .done(done2), .busy(busy2), .overflow(ov2), .load_idx(idx2)
  );

  // Route the outputs of the selected instance to the r_* signals.
  always_comb begin
    r_res  = 16'h0;
    r_done = 1'b0;
    r_busy = 1'b0;
    r_ov   = 1'b0;
    r_idx  = 4'h0;
    case (sel)
      0: begin r_res = {8'h00, res0}; r_done = done0; r_busy = busy0; r_ov = ov0; r_idx = idx0; end
      1: begin r_res = res1; r_done = done1; r_busy = busy1; r_ov = ov1; r_idx = idx1; end
      default: begin r_res = res2; r_done = done2; r_busy = busy2; r_ov = ov2; r_idx = idx2; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load vec[0..n-1] into the selected instance, one go strobe per value.
  // Each strobe is held for 'hold' clock edges.
  task automatic load_all(input string tag, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      check({tag, "_idx"}, 32'(r_idx), i);
      if (i == 1) begin
        check({tag, "_res_held"}, 32'(r_res), 32'(last_res[sel]));
        check({tag, "_ov_held"}, 32'(r_ov), 32'(last_ov[sel]));
      end
      data_in = vec[i];
      go_v[sel] = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      if (hold > 1) check({tag, "_hold_idx"}, 32'(r_idx), i);
      go_v[sel] = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Check compute latency from INIT entry, the result, the flag and the single done pulse.
  task automatic finish_check(input string tag, input int deg, input logic [15:0] exp_res,
                              input logic exp_ov);
    int w = 0;
    int n = 0;
    while (!r_busy && w < 4) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({tag, "_busy"}, 32'(r_busy), 1);
    while (!r_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 1 + 2 * deg);
    check({tag, "_res"}, 32'(r_res), 32'(exp_res));
    check({tag, "_ov"}, 32'(r_ov), 32'(exp_ov));
    check({tag, "_busy_end"}, 32'(r_busy), 0);
    last_res[sel] = exp_res;
    last_ov[sel]  = exp_ov;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(r_done), 0);
    check({tag, "_idx_end"}, 32'(r_idx), 0);
  endtask

  task automatic run(input string tag, input int deg, input int hold,
                     input logic [15:0] exp_res, input logic exp_ov);
    load_all(tag, deg + 2, hold);
    finish_check(tag, deg, exp_res, exp_ov);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int k;
    sel     = 0;
    go_v    = 3'b000;
    data_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      last_res[i] = 16'h0;
      last_ov[i]  = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", 32'(r_res), 0);
    check("rst_done", 32'(r_done), 0);
    check("rst_busy", 32'(r_busy), 0);
    check("rst_ov", 32'(r_ov), 0);
    check("rst_idx", 32'(r_idx), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Nominal case: 2x^2+3x+4 at x=5 gives 69.
    vec = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0};
    run("nominal", 2, 1, 16'd69, 1'b0);

    // Overflow case: 16x^2 at x=16 is 4096, which reduces to 0 modulo 256.
    vec = '{16'd16, 16'd0, 16'd0, 16'd16, 16'd0, 16'd0};
    run("ovf", 2, 1, 16'd0, 1'b1);
    // The flag clears on the next run: 1+1+1 = 3.
    vec = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0};
    run("ovf_clear", 2, 1, 16'd3, 1'b0);

    // Hold go for 20 cycles on each value: one capture per value.
    vec = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0};
    run("held_go", 2, 20, 16'd69, 1'b0);

    // Toggle go on every cycle while busy: it is ignored.
    vec = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0};
    load_all("toggle", 4, 1);
    bad = 0;
    k   = 0;
    while (r_busy && k < 50) begin
      go_v[0] = ~go_v[0];
      @(posedge clk);
      #1;
      k++;
      if (r_busy && r_idx != 4'd3) bad++;
    end
    go_v[0] = 1'b0;
    check("toggle_latency", k, 5);
    check("toggle_done", 32'(r_done), 1);
    check("toggle_res", 32'(r_res), 69);
    check("toggle_idx_stable", bad, 0);
    @(posedge clk);
    #1;
    check("toggle_no_capture", 32'(r_idx), 0);

    // Reset in the second MUL cycle: outputs clear without a clock edge.
    vec = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0};
    load_all("midrst", 4, 1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(r_busy), 1);
    resetn = 1'b0;
    #1;
    check("midrst_res", 32'(r_res), 0);
    check("midrst_busy", 32'(r_busy), 0);
    check("midrst_done", 32'(r_done), 0);
    check("midrst_ov", 32'(r_ov), 0);
    check("midrst_idx", 32'(r_idx), 0);
    bad = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (r_done) bad++;
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (r_done) bad++;
    end
    check("midrst_no_done", bad, 0);
    for (int i = 0; i < 3; i++) begin
      last_res[i] = 16'h0;
      last_ov[i]  = 1'b0;
    end
    run("after_rst", 2, 1, 16'd69, 1'b0);

    // DEGREE=1, DATA_W=16.
    sel = 1;
    vec = '{16'd3, 16'd7, 16'd1000, 16'd0, 16'd0, 16'd0};
    run("d1_a", 1, 1, 16'd3007, 1'b0);
    vec = '{16'hFFFF, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0};
    run("d1_mulovf", 1, 1, 16'h0000, 1'b1);
    vec = '{16'd1, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0};
    run("d1_carry", 1, 1, 16'h0000, 1'b1);

    // DEGREE=4, DATA_W=16.
    sel = 2;
    vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd10};
    run("d4_a", 4, 1, 16'd12345, 1'b0);
    vec = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd16};
    run("d4_ovf", 4, 1, 16'h0000, 1'b1);
    vec = '{16'h0100, 16'd0, 16'd0, 16'd0, 16'h1234, 16'd2};
    run("d4_c", 4, 1, 16'h2234, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
